// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: instruction registers for stages 1..STAGES after fetch.
// Inserts interlock bubbles on read-after-write hazards, flushes on PC load,
// freezes on halt and counts inserted bubbles with a saturating counter.
module pipeline_sequencer #(
  parameter int INSTR_W = 16,
  parameter int STAGES  = 2,
  parameter int RADDR_W = 5,
  parameter int RD_LSB  = 8,
  parameter int RS1_LSB = 8,
  parameter int RS2_LSB = 3,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INSTR_W-1:0]        instr,
  input  logic                      dec_wr,
  input  logic                      dec_rs1,
  input  logic                      dec_rs2,
  input  logic                      flush,
  input  logic                      halt,
  output logic [STAGES*INSTR_W-1:0] stage_instr,
  output logic [STAGES-1:0]         stage_valid,
  output logic [RADDR_W-1:0]        wr_addr,
  output logic                      wr_valid,
  output logic                      fetch_en,
  output logic [15:0]               bubble_cnt
);

  // Per-stage instruction, valid and write flags. Source-use flags are only
  // ever consulted while the instruction sits in stage 1, so only stage 1 keeps them.
  logic [INSTR_W-1:0] instr_q [1:STAGES];
  logic [STAGES:1]    vld_q;
  logic [STAGES:1]    wr_q;
  logic               rs1_q;
  logic               rs2_q;
  logic [15:0]        bubble_cnt_q;
  logic               hazard;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // RAW check: stage 1 sources against every older in-flight writer (no bypass).
  always_comb begin
    hazard = 1'b0;
    for (int k = 2; k <= STAGES; k++) begin
      if (vld_q[1] && vld_q[k] && wr_q[k]) begin
        if (rs1_q && (instr_q[k][RD_LSB +: RADDR_W] == instr_q[1][RS1_LSB +: RADDR_W]))
          hazard = 1'b1;
        if (rs2_q && (instr_q[k][RD_LSB +: RADDR_W] == instr_q[1][RS2_LSB +: RADDR_W]))
          hazard = 1'b1;
      end
    end
  end

  // Stage registers: halt > flush > interlock bubble > normal advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= STAGES; k++) instr_q[k] <= NOP_INSTR;
      vld_q        <= '0;
      wr_q         <= '0;
      rs1_q        <= 1'b0;
      rs2_q        <= 1'b0;
      bubble_cnt_q <= '0;
    end else if (!halt) begin
      if (flush) begin
        for (int k = 1; k <= STAGES; k++) instr_q[k] <= NOP_INSTR;
        vld_q <= '0;
        wr_q  <= '0;
        rs1_q <= 1'b0;
        rs2_q <= 1'b0;
      end else if (hazard) begin
        // stage 1 holds its reader; a bubble enters stage 2; older stages drain
        instr_q[2] <= NOP_INSTR;
        vld_q[2]   <= 1'b0;
        wr_q[2]    <= 1'b0;
        for (int k = 3; k <= STAGES; k++) begin
          instr_q[k] <= instr_q[k-1];
          vld_q[k]   <= vld_q[k-1];
          wr_q[k]    <= wr_q[k-1];
        end
        bubble_cnt_q <= sat_inc(bubble_cnt_q);
      end else begin
        instr_q[1] <= instr;
        vld_q[1]   <= 1'b1;
        wr_q[1]    <= dec_wr;
        rs1_q      <= dec_rs1;
        rs2_q      <= dec_rs2;
        for (int k = 2; k <= STAGES; k++) begin
          instr_q[k] <= instr_q[k-1];
          vld_q[k]   <= vld_q[k-1];
          wr_q[k]    <= wr_q[k-1];
        end
      end
    end
  end

  genvar g;
  for (g = 1; g <= STAGES; g++) begin : g_pack
    assign stage_instr[(g-1)*INSTR_W +: INSTR_W] = instr_q[g];
  end

  assign stage_valid = vld_q;
  assign wr_addr     = instr_q[STAGES][RD_LSB +: RADDR_W];
  assign wr_valid    = vld_q[STAGES] & wr_q[STAGES];
  assign fetch_en    = !halt && !hazard;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Parametrised instruction-pipeline sequencer for the RISC core: holds the per-stage instruction registers (stage 1 .. STAGES) that sit after the fetch stage, and drives stage-local control decoders and register-file addresses from them.
- Generalises the fixed two-register pipeline to any depth.
- Adds a hardware RAW interlock that inserts bubbles, so software no longer pads dependent instructions with NOPs.
- Adds flush on PC load, a halt freeze and a saturating bubble counter.

Parameters:
- INSTR_W, 16, instruction width.
- STAGES, 2, number of pipeline stages after fetch; legal range 2..6.
- RADDR_W, 5, register address width.
- RD_LSB, 8, LSB of the destination field rd.
- RS1_LSB, 8, LSB of the source-1 field.
- RS2_LSB, 3, LSB of the source-2 field.
- NOP_INSTR, 0, encoding used for bubbles and for reset.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr  in  INSTR_W  instruction from instruction memory (fetch stage)
- dec_wr  in  1  instr writes register rd (combinational pre-decode of instr)
- dec_rs1  in  1  instr reads the rs1 field
- dec_rs2  in  1  instr reads the rs2 field
- flush  in  1  PC load issued by the last stage (taken jump, call, return)
- halt  in  1  freeze the whole pipeline
- stage_instr  out  STAGES*INSTR_W  stage k occupies bits [k*INSTR_W-1 : (k-1)*INSTR_W]
- stage_valid  out  STAGES  1 = stage holds a real instruction, 0 = bubble
- wr_addr  out  RADDR_W  rd field of stage STAGES
- wr_valid  out  1  stage STAGES is valid and writes rd
- fetch_en  out  1  PC may advance this cycle
- bubble_cnt  out  16  count of inserted interlock bubbles

Behaviour:
- Reset (asynchronous, active-low, applied at any time including mid-stall or mid-flush):
  - every stage_instr = NOP_INSTR, stage_valid = 0, all stored wr flags and source flags = 0, bubble_cnt = 0.
  - fetch_en follows from the cleared state: it is 1 after reset unless halt is high.
- Per-stage storage: instruction, valid bit, wr flag, rs1-used flag, rs2-used flag. All flags are captured from the dec_* inputs when an instruction enters stage 1.
- Register file timing, no bypass:
  - stage STAGES writes at the clock edge that ends its cycle;
  - stage 1 reads at the clock edge that ends its cycle.
- Hazard (combinational), asserted when stage 1 is valid and, for any k in 2..STAGES:
  - stage k is valid, has its wr flag set, and its rd equals the rs1 of stage 1 with the rs1-used flag set; or
  - the same condition holds against the rs2 of stage 1 with the rs2-used flag set.
- Stage 1 versus stage 1 is never a hazard.
- fetch_en = !halt && !hazard. Purely combinational, no registered delay.
- Clock-edge update, priority order highest first:
  1. halt: all state holds and bubble_cnt holds.
  2. flush: all stages become NOP_INSTR with valid = 0, dropping the younger instructions fetched after the jump. The flushing instruction itself leaves stage STAGES normally. Flush overrides any hazard, and bubble_cnt does not increment.
  3. hazard: stage 1 and the fetch input hold; stage 2 receives a bubble (NOP, valid = 0); stages 3..STAGES shift normally; bubble_cnt increments.
  4. normal: stage 1 <= instr together with its dec_* flags, valid = 1; stage k <= stage k-1 for k = 2..STAGES.
- bubble_cnt saturates at 16'hFFFF and never wraps.
- Bubble count for a dependent pair X (writer) then Y (reader) issued back-to-back: exactly STAGES-1 bubbles. Each instruction of separation removes one bubble, with a minimum of 0.
- wr_valid = stage_valid[STAGES] && wr flag of stage STAGES. wr_addr is always the rd field of stage STAGES, even when the stage holds a bubble.
- halt asserted during a hazard stall: the stall is frozen; it resumes with the same remaining bubble count once halt deasserts.
- flush and halt asserted in the same cycle: halt wins; the flush is lost unless flush is still asserted when halt drops. The control unit holds flush until it sees no halt.
- No combinational path from instr to any output except through the registers. Only fetch_en depends combinationally, and only on halt and registered state.

Test Plan:
- STAGES=2, rd at 12:8, rs1 at 12:8, rs2 at 7:3, writer rd = R3 (dec_wr=1, instr 16'h2300) then reader with rs2 = R3 (dec_rs2=1, instr 16'h2418): exactly 1 bubble; fetch_en low for 1 cycle; bubble_cnt = 1; reader reaches stage 2 two cycles after the writer.
- Same dependent pair with STAGES=4: 3 bubbles, bubble_cnt = 3. Repeat with one independent instruction between writer and reader: 2 bubbles.
- Independent stream (distinct rd/rs, 10 instructions): fetch_en never low, bubble_cnt = 0, instructions emerge at stage STAGES in order, one per cycle.
- Flush pulsed while stage 1 holds a hazard-stalled reader: next cycle every stage_valid = 0, bubble_cnt unchanged, fetch_en = 1.
- halt raised during the first bubble of a STAGES=4 stall for 5 cycles, then dropped: outputs frozen for 5 cycles; 2 further bubbles follow; final bubble_cnt = 3.
- reset pulsed low mid-stall with bubble_cnt = 7: immediately all stages NOP/invalid and bubble_cnt = 0. Separately, force the counter to 16'hFFFF with one further hazard: it stays at 16'hFFFF.
